// File: rtl/sm83_bus_pkg.sv
// Shared types for the SM83 bus interface unit: bus owner codes, T-states,
// and helpers used by the scheduler and the phase generator.
package sm83_bus_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } bus_owner_t;

  typedef enum logic [1:0] {
    T1 = 2'd0,
    T2 = 2'd1,
    T3 = 2'd2,
    T4 = 2'd3
  } tstate_t;

  function automatic tstate_t next_tstate(input tstate_t s);
    case (s)
      T1:      return T2;
      T2:      return T3;
      T3:      return T4;
      default: return T1;
    endcase
  endfunction

  // A burst limit of 0 still needs a one-bit counter to keep the port legal.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sm83_tstate_gen.sv
// Four-phase T-state generator with a freeze input; resets into T4 so the
// first enabled edge enters T1.
module sm83_tstate_gen
  import sm83_bus_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_phase_en,
  output logic o_t1,
  output logic o_t2,
  output logic o_t3,
  output logic o_t4
);

  tstate_t r_phase;

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= T4;
    end else if (i_phase_en) begin
      r_phase <= next_tstate(r_phase);
    end
  end

  assign o_t1 = (r_phase == T1);
  assign o_t2 = (r_phase == T2);
  assign o_t3 = (r_phase == T3);
  assign o_t4 = (r_phase == T4);

endmodule

// File: rtl/sm83_bus_sched.sv
// M-cycle scheduler: arbitrates the external bus between CPU and OAM DMA at
// each T4 boundary and reports per-requester completion one M-cycle later.
module sm83_bus_sched
  import sm83_bus_pkg::*;
#(
  parameter int unsigned DMA_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        phase_en,
  output logic        t1,
  output logic        t2,
  output logic        t3,
  output logic        t4,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  output logic        cpu_wait,
  output logic        cpu_done,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  output logic        dma_done,
  output logic        mread,
  output logic        mwrite,
  output logic [15:0] ain,
  output logic        apin_we,
  output logic [1:0]  owner
);

  localparam int unsigned CNT_W = cnt_width(DMA_BURST_MAX);
  localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(DMA_BURST_MAX);

  bus_owner_t       r_owner;
  logic [CNT_W-1:0] r_burst_cnt;

  logic w_boundary;
  logic w_cpu_starved;
  logic w_dma_grant;
  logic w_cpu_grant;

  sm83_tstate_gen u_tstate (
    .clk        (clk),
    .reset      (reset),
    .i_phase_en (phase_en),
    .o_t1       (t1),
    .o_t2       (t2),
    .o_t3       (t3),
    .o_t4       (t4)
  );

  // Reset is folded into the boundary so no strobe leaks out while the phase
  // register is still being forced back to T4.
  assign w_boundary    = t4 && phase_en && !reset;
  assign w_cpu_starved = cpu_req && (DMA_BURST_MAX != 0) && (r_burst_cnt == BURST_LIMIT);
  assign w_dma_grant   = w_boundary && dma_req && !w_cpu_starved;
  assign w_cpu_grant   = w_boundary && cpu_req && !w_dma_grant;

  assign mread    = w_dma_grant || (w_cpu_grant && !cpu_we);
  assign mwrite   = w_cpu_grant && cpu_we;
  assign apin_we  = w_dma_grant || w_cpu_grant;
  assign ain      = w_dma_grant ? dma_addr : (w_cpu_grant ? cpu_addr : 16'h0000);
  assign cpu_wait = w_boundary && cpu_req && !w_cpu_grant;
  assign cpu_done = w_boundary && (r_owner == OWN_CPU);
  assign dma_done = w_boundary && (r_owner == OWN_DMA);
  assign owner    = r_owner;

  // The burst counter only tracks DMA cycles taken while the CPU is waiting;
  // any CPU grant or idle CPU at the boundary restarts the fairness window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner     <= OWN_NONE;
      r_burst_cnt <= '0;
    end else if (w_boundary) begin
      r_owner <= w_dma_grant ? OWN_DMA : (w_cpu_grant ? OWN_CPU : OWN_NONE);
      if (w_cpu_grant || !cpu_req) begin
        r_burst_cnt <= '0;
      end else if (w_dma_grant && (r_burst_cnt != BURST_LIMIT)) begin
        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sm83_bus_sched.sv
// Scoreboard bench for sm83_bus_sched: two instances (burst limit 4 and 0)
// driven by the same stimulus and compared against a rule-level model.
module tb_sm83_bus_sched;

  localparam int unsigned LIM_A = 4;
  localparam int unsigned LIM_B = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset    = 1'b1;
  logic        phase_en = 1'b0;
  logic        cpu_req  = 1'b0;
  logic        cpu_we   = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic        dma_req  = 1'b0;
  logic [15:0] dma_addr = 16'h0000;

  logic        t1_a, t2_a, t3_a, t4_a, cpu_wait_a, cpu_done_a, dma_done_a;
  logic        mread_a, mwrite_a, apin_we_a;
  logic [15:0] ain_a;
  logic [1:0]  owner_a;
  logic        t1_b, t2_b, t3_b, t4_b, cpu_wait_b, cpu_done_b, dma_done_b;
  logic        mread_b, mwrite_b, apin_we_b;
  logic [15:0] ain_b;
  logic [1:0]  owner_b;

  sm83_bus_sched #(.DMA_BURST_MAX(LIM_A)) dut_a (
    .clk(clk), .reset(reset), .phase_en(phase_en),
    .t1(t1_a), .t2(t2_a), .t3(t3_a), .t4(t4_a),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wait(cpu_wait_a), .cpu_done(cpu_done_a),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_done(dma_done_a),
    .mread(mread_a), .mwrite(mwrite_a), .ain(ain_a), .apin_we(apin_we_a),
    .owner(owner_a)
  );

  sm83_bus_sched #(.DMA_BURST_MAX(LIM_B)) dut_b (
    .clk(clk), .reset(reset), .phase_en(phase_en),
    .t1(t1_b), .t2(t2_b), .t3(t3_b), .t4(t4_b),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wait(cpu_wait_b), .cpu_done(cpu_done_b),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_done(dma_done_b),
    .mread(mread_b), .mwrite(mwrite_b), .ain(ain_b), .apin_we(apin_we_b),
    .owner(owner_b)
  );

  typedef struct packed {
    logic [3:0]  t;
    logic        cpu_wait;
    logic        cpu_done;
    logic        dma_done;
    logic        mread;
    logic        mwrite;
    logic        apin_we;
    logic [1:0]  owner;
    logic [15:0] ain;
  } obs_t;

  typedef struct packed {
    logic chk;
    obs_t a;
    obs_t b;
  } exp_t;

  obs_t act_a, act_b;
  assign act_a = {t4_a, t3_a, t2_a, t1_a, cpu_wait_a, cpu_done_a, dma_done_a,
                  mread_a, mwrite_a, apin_we_a, owner_a, ain_a};
  assign act_b = {t4_b, t3_b, t2_b, t1_b, cpu_wait_b, cpu_done_b, dma_done_b,
                  mread_b, mwrite_b, apin_we_b, owner_b, ain_b};

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: phase index 0..3 (3 = T4), owner code, and the number of
  // consecutive DMA cycles the CPU has already sat through.
  int ph       = 0;
  bit ph_known = 1'b0;
  int own[2]   = '{0, 0};
  int streak[2] = '{0, 0};

  function automatic int lim(input int i);
    return (i == 0) ? int'(LIM_A) : int'(LIM_B);
  endfunction

  // 0 = no grant, 1 = CPU, 2 = DMA
  function automatic int grant(input int i);
    if (reset || !phase_en || ph != 3) return 0;
    if (dma_req && !(cpu_req && lim(i) != 0 && streak[i] == lim(i))) return 2;
    if (cpu_req) return 1;
    return 0;
  endfunction

  function automatic obs_t predict(input int i);
    obs_t o;
    int   g;
    bit   bnd;
    o   = '0;
    g   = grant(i);
    bnd = !reset && phase_en && ph == 3;
    o.t[ph]     = 1'b1;
    o.cpu_wait  = bnd && cpu_req && g != 1;
    o.cpu_done  = bnd && own[i] == 1;
    o.dma_done  = bnd && own[i] == 2;
    o.mread     = (g == 2) || (g == 1 && !cpu_we);
    o.mwrite    = (g == 1) && cpu_we;
    o.apin_we   = (g != 0);
    o.owner     = 2'(own[i]);
    o.ain       = (g == 2) ? dma_addr : ((g == 1) ? cpu_addr : 16'h0000);
    return o;
  endfunction

  task automatic advance();
    int g;
    if (reset) begin
      ph = 3; ph_known = 1'b1;
      own = '{0, 0}; streak = '{0, 0};
    end else if (phase_en) begin
      for (int i = 0; i < 2; i++) begin
        if (ph == 3) begin
          g = grant(i);
          own[i] = g;
          if (g == 1 || !cpu_req) streak[i] = 0;
          else if (g == 2 && streak[i] < lim(i)) streak[i] = streak[i] + 1;
        end
      end
      ph = (ph + 1) % 4;
    end
  endtask

  task automatic step(input bit rst, input bit pe, input bit creq, input bit cwe,
                      input logic [15:0] ca, input bit dreq, input logic [15:0] da);
    exp_t e;
    reset = rst; phase_en = pe; cpu_req = creq; cpu_we = cwe; cpu_addr = ca;
    dma_req = dreq; dma_addr = da;
    e.chk = ph_known;
    e.a   = predict(0);
    e.b   = predict(1);
    exp_q.push_back(e);
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 0, 0, 16'h0000, 0, 16'h0000);
  endtask

  task automatic align_t4();
    for (int k = 0; k < 4 && ph != 3; k++) idle(1);
  endtask

  task automatic check(input string name, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got t=%b wait=%b cdone=%b ddone=%b rd=%b wr=%b ld=%b own=%0d ain=%h, expected t=%b wait=%b cdone=%b ddone=%b rd=%b wr=%b ld=%b own=%0d ain=%h",
               name, $time, act.t, act.cpu_wait, act.cpu_done, act.dma_done, act.mread,
               act.mwrite, act.apin_we, act.owner, act.ain, exp.t, exp.cpu_wait,
               exp.cpu_done, exp.dma_done, exp.mread, exp.mwrite, exp.apin_we,
               exp.owner, exp.ain);
    end
  endtask

  // Monitor: consumes one expectation per cycle, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          check("obs_lim4", act_a, e.a);
          check("obs_lim0", act_b, e.b);
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    step(1, 1, 0, 0, 16'h0000, 0, 16'h0000);
    step(1, 1, 0, 0, 16'h0000, 0, 16'h0000);
    idle(12);

    // Single CPU read
    align_t4();
    step(0, 1, 1, 0, 16'hC123, 0, 16'h0000);
    idle(8);

    // CPU write contending with DMA for 11 boundaries
    align_t4();
    for (int k = 0; k < 44; k++) step(0, 1, 1, 1, 16'h8000 + 16'(k), 1, 16'hFE00 + 16'(k));
    idle(8);

    // Phase frozen for 3 clocks during T2 of a CPU read
    align_t4();
    step(0, 1, 1, 0, 16'h1234, 0, 16'h0000);
    idle(1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 16'h0000, 0, 16'h0000);
    idle(8);

    // Reset at T3 of a DMA cycle with a CPU request pending
    align_t4();
    step(0, 1, 0, 0, 16'h0000, 1, 16'hFE10);
    idle(2);
    step(1, 1, 1, 0, 16'hD000, 0, 16'h0000);
    step(0, 1, 1, 0, 16'hD000, 0, 16'h0000);
    idle(6);

    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 16'($urandom),
           $urandom_range(0, 3) != 0, 16'($urandom));
    end
    idle(4);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
